arp_tx: RTL

ARP frame transmitter: builds complete 60-byte Ethernet/ARP frames (no preamble, no FCS) and streams them one byte per handshake on an AXI-Stream-style master port. It serves the ARP cache/controller: it sends a reply when the controller raises `arp_resp_start` and a broadcast request when it pulses `arp_rq_start`. It sits between the ARP controller and the TX MAC, which appends the FCS and enforces the IFG.

---
 rtl/arp_pkg.sv | 25 ++
 rtl/arp_tx_if.sv | 23 ++
 rtl/arp_tx.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/arp_pkg.sv
// Shared ARP/Ethernet constants and the enums used by the ARP transmitter.
package arp_pkg;

  localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
  localparam logic [15:0] HTYPE_ETH      = 16'h0001;
  localparam logic [15:0] PTYPE_IPV4     = 16'h0800;
  localparam logic [7:0]  HLEN           = 8'd6;
  localparam logic [7:0]  PLEN           = 8'd4;
  localparam logic [15:0] ARP_OPER_REQ   = 16'd1;
  localparam logic [15:0] ARP_OPER_REPLY = 16'd2;

  localparam int unsigned ARP_FRAME_LEN  = 60;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_e;

  typedef enum logic {
    REQUEST,
    REPLY
  } op_e;

endpackage

// File: rtl/arp_tx_if.sv
// Byte-wide AXI-Stream-style link from the ARP transmitter to the TX MAC.
interface arp_tx_if;

  logic [7:0] m_tdata;
  logic       m_tvalid;
  logic       m_tready;
  logic       m_tlast;

  modport master (
    output m_tdata,
    output m_tvalid,
    output m_tlast,
    input  m_tready
  );

  modport slave (
    input  m_tdata,
    input  m_tvalid,
    input  m_tlast,
    output m_tready
  );

endinterface

// File: rtl/arp_tx.sv
// Builds 60-byte Ethernet/ARP reply or request frames from snapshotted addresses and streams
// them one byte per handshake.
module arp_tx
  import arp_pkg::*;
#(
  parameter int unsigned FRAME_LEN = ARP_FRAME_LEN
) (
  input  logic        aclk,
  input  logic        aresetn,

  input  logic [47:0] local_mac,
  input  logic [31:0] local_ip,
  input  logic [47:0] peer_mac,
  input  logic [31:0] peer_ip,

  input  logic        arp_resp_start,
  output logic        arp_resp_end,
  input  logic        arp_rq_start,
  output logic        arp_rq_done,
  output logic        busy,

  arp_tx_if.master    m_axis
);

  localparam logic [5:0] LAST_IDX = 6'(FRAME_LEN - 1);

  state_e      state;
  op_e         op;
  op_e         launch_op;
  logic [5:0]  idx;
  logic [47:0] snap_local_mac;
  logic [31:0] snap_local_ip;
  logic [47:0] snap_peer_mac;
  logic [31:0] snap_peer_ip;
  logic        resp_prev;
  logic        resp_pend;
  logic        rq_pend;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tlast;

  logic        hs;
  logic        launch_resp;
  logic        launch_rq;

  // The 42-byte header is laid out MSB first, so byte i is the top byte after shifting by i.
  function automatic logic [7:0] frame_byte(input logic [5:0]  i,
                                            input op_e         o,
                                            input logic [47:0] lm,
                                            input logic [31:0] li,
                                            input logic [47:0] pm,
                                            input logic [31:0] pi);
    logic [335:0] hdr;
    logic [335:0] sh;
    hdr = {(o == REPLY) ? pm : {6{8'hFF}},
           lm,
           ETHERTYPE_ARP,
           HTYPE_ETH,
           PTYPE_IPV4,
           HLEN,
           PLEN,
           (o == REPLY) ? ARP_OPER_REPLY : ARP_OPER_REQ,
           lm,
           li,
           (o == REPLY) ? pm : 48'h0,
           pi};
    sh = hdr << (8 * i);
    return (i < 6'd42) ? sh[335:328] : 8'h00;
  endfunction

  always_comb begin
    hs          = tvalid & m_axis.m_tready;
    launch_resp = (state == IDLE) & resp_pend;
    launch_rq   = (state == IDLE) & ~resp_pend & rq_pend;
    launch_op   = resp_pend ? REPLY : REQUEST;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state          <= IDLE;
      op             <= REQUEST;
      idx            <= 6'd0;
      snap_local_mac <= 48'h0;
      snap_local_ip  <= 32'h0;
      snap_peer_mac  <= 48'h0;
      snap_peer_ip   <= 32'h0;
      resp_prev      <= 1'b0;
      resp_pend      <= 1'b0;
      rq_pend        <= 1'b0;
      tdata          <= 8'h00;
      tvalid         <= 1'b0;
      tlast          <= 1'b0;
      arp_resp_end   <= 1'b0;
      arp_rq_done    <= 1'b0;
      busy           <= 1'b0;
    end else begin
      // Triggers are captured in every state so a request arriving mid-frame is not lost.
      resp_prev    <= arp_resp_start;
      resp_pend    <= (resp_pend & ~launch_resp) | (arp_resp_start & ~resp_prev);
      rq_pend      <= (rq_pend & ~launch_rq) | arp_rq_start;
      arp_resp_end <= 1'b0;
      arp_rq_done  <= 1'b0;

      unique case (state)
        IDLE: begin
          if (resp_pend || rq_pend) begin
            op             <= launch_op;
            snap_local_mac <= local_mac;
            snap_local_ip  <= local_ip;
            snap_peer_mac  <= peer_mac;
            snap_peer_ip   <= peer_ip;
            idx            <= 6'd0;
            // Byte 0 is built from the live inputs, which are what the snapshot captures now.
            tdata          <= frame_byte(6'd0, launch_op, local_mac, local_ip, peer_mac, peer_ip);
            tvalid         <= 1'b1;
            tlast          <= (LAST_IDX == 6'd0);
            busy           <= 1'b1;
            state          <= SEND;
          end
        end

        SEND: begin
          if (hs) begin
            if (idx == LAST_IDX) begin
              idx          <= 6'd0;
              tdata        <= 8'h00;
              tvalid       <= 1'b0;
              tlast        <= 1'b0;
              arp_resp_end <= (op == REPLY);
              arp_rq_done  <= (op == REQUEST);
              state        <= DONE;
            end else begin
              idx   <= idx + 6'd1;
              tdata <= frame_byte(idx + 6'd1, op, snap_local_mac, snap_local_ip,
                                  snap_peer_mac, snap_peer_ip);
              tlast <= ((idx + 6'd1) == LAST_IDX);
            end
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign m_axis.m_tdata  = tdata;
  assign m_axis.m_tvalid = tvalid;
  assign m_axis.m_tlast  = tlast;

endmodule
